// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage F/D/E/M/W core: forwarding, load-use stalls, branch flushes, dmem waits.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush performance counters (tied to 0 otherwise).
module hazard_ctrl #(
   parameter int ADDR_W   = 5,
   parameter int NUM_SRC  = 2,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 32
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NUM_SRC*ADDR_W-1:0] i_rs_addr_d,
   input  logic [NUM_SRC*ADDR_W-1:0] i_rs_addr_e,
   input  logic [ADDR_W-1:0]         i_rd_addr_e,
   input  logic                      i_regwrite_e,
   input  logic                      i_memread_e,
   input  logic [ADDR_W-1:0]         i_rd_addr_m,
   input  logic                      i_regwrite_m,
   input  logic [ADDR_W-1:0]         i_rd_addr_w,
   input  logic                      i_regwrite_w,
   input  logic                      i_pcsrc_e,
   input  logic                      i_dmem_busy,
   output logic [NUM_SRC*2-1:0]      o_fwd_sel,
   output logic                      o_stall_f,
   output logic                      o_stall_d,
   output logic                      o_stall_e,
   output logic                      o_stall_m,
   output logic                      o_flush_d,
   output logic                      o_flush_e,
   output logic                      o_flush_w,
   output logic [CNT_W-1:0]          o_stall_cnt,
   output logic [CNT_W-1:0]          o_flush_cnt
);

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      LOAD_WAIT = 2'd1,
      MEM_WAIT  = 2'd2
   } state_t;

   localparam int            BW     = 4;
   localparam logic [BW-1:0] LAT_M1 = BW'(LOAD_LAT - 1);

   state_t        state_q, state_d, ret_q, ret_d, eff_state;
   logic [BW-1:0] bub_q, bub_d;
   logic          load_use;
   logic          st_f, st_d, st_e, st_m, fl_d, fl_e, fl_w;

   always_comb begin
      o_fwd_sel = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (i_rst) begin
            o_fwd_sel[2*k +: 2] = 2'b00;
         end else if (i_regwrite_m && (i_rd_addr_m != '0) &&
                      (i_rd_addr_m == i_rs_addr_e[k*ADDR_W +: ADDR_W])) begin
            o_fwd_sel[2*k +: 2] = 2'b10;
         end else if (i_regwrite_w && (i_rd_addr_w != '0) &&
                      (i_rd_addr_w == i_rs_addr_e[k*ADDR_W +: ADDR_W])) begin
            o_fwd_sel[2*k +: 2] = 2'b01;
         end
      end
   end

   always_comb begin
      load_use = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (i_rd_addr_e == i_rs_addr_d[k*ADDR_W +: ADDR_W]) load_use = 1'b1;
      end
      load_use = load_use && i_memread_e && i_regwrite_e && (i_rd_addr_e != '0);
   end

   // A MEM_WAIT cycle with busy already low behaves as the state it will return to.
   always_comb begin
      state_d   = state_q;
      ret_d     = ret_q;
      bub_d     = bub_q;
      st_f      = 1'b0;
      st_d      = 1'b0;
      st_e      = 1'b0;
      st_m      = 1'b0;
      fl_d      = 1'b0;
      fl_e      = 1'b0;
      fl_w      = 1'b0;
      eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;
      if (i_dmem_busy) begin
         st_f    = 1'b1;
         st_d    = 1'b1;
         st_e    = 1'b1;
         st_m    = 1'b1;
         fl_w    = 1'b1;
         state_d = MEM_WAIT;
         if (state_q != MEM_WAIT) ret_d = state_q;
      end else if (eff_state == LOAD_WAIT) begin
         ret_d = RUN;
         if (i_pcsrc_e) begin
            fl_d    = 1'b1;
            fl_e    = 1'b1;
            state_d = RUN;
            bub_d   = '0;
         end else begin
            st_f = 1'b1;
            st_d = 1'b1;
            fl_e = 1'b1;
            if (bub_q <= BW'(1)) begin
               state_d = RUN;
               bub_d   = '0;
            end else begin
               state_d = LOAD_WAIT;
               bub_d   = bub_q - BW'(1);
            end
         end
      end else begin
         state_d = RUN;
         ret_d   = RUN;
         if (i_pcsrc_e) begin
            fl_d = 1'b1;
            fl_e = 1'b1;
         end else if (load_use) begin
            st_f = 1'b1;
            st_d = 1'b1;
            fl_e = 1'b1;
            if (LOAD_LAT > 1) begin
               state_d = LOAD_WAIT;
               bub_d   = LAT_M1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= RUN;
         ret_q   <= RUN;
         bub_q   <= '0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         bub_q   <= bub_d;
      end
   end

   assign o_stall_f = st_f & ~i_rst;
   assign o_stall_d = st_d & ~i_rst;
   assign o_stall_e = st_e & ~i_rst;
   assign o_stall_m = st_m & ~i_rst;
   assign o_flush_d = fl_d & ~i_rst;
   assign o_flush_e = fl_e & ~i_rst;
   assign o_flush_w = fl_w & ~i_rst;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // Only a taken branch raises o_flush_d, so it doubles as the branch-flush strobe.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (o_stall_d) stall_cnt_q <= sat_inc(stall_cnt_q);
         if (o_flush_d) flush_cnt_q <= sat_inc(flush_cnt_q);
      end
   end

   assign o_stall_cnt = stall_cnt_q;
   assign o_flush_cnt = flush_cnt_q;
`else
   assign o_stall_cnt = '0;
   assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOAD_LAT=1/CNT_W=32 and LOAD_LAT=3/CNT_W=3) against a bubble-count model.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   localparam logic [10:0] V_LU = 11'b0000_1100010;
   localparam logic [10:0] V_MW = 11'b0000_1111001;
   localparam logic [10:0] V_BR = 11'b0000_0000110;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rwe, mre, rwm, rww, pcsrc, busy;
   logic [9:0]  rs_d, rs_e;
   logic [4:0]  rd_e, rd_m, rd_w;
   logic [3:0]  fwd1, fwd3;
   logic        sf1, sd1, se1, sm1, fd1, fe1, fw1;
   logic        sf3, sd3, se3, sm3, fd3, fe3, fw3;
   logic [31:0] sc1, fc1;
   logic [2:0]  sc3, fc3;
   logic [10:0] act1, act3;

   int          checks = 0;
   int          errors = 0;
   int          lat_tab[2] = '{1, 3};
   longint      cmax[2]    = '{64'h0000_0000_FFFF_FFFF, 64'd7};
   int          left[2], nleft[2];
   longint      msc[2], mfc[2];
   logic [10:0] exp_o[2];

   hazard_ctrl #(.ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(32)) u1 (
      .i_clk(clk), .i_rst(rst), .i_rs_addr_d(rs_d), .i_rs_addr_e(rs_e),
      .i_rd_addr_e(rd_e), .i_regwrite_e(rwe), .i_memread_e(mre),
      .i_rd_addr_m(rd_m), .i_regwrite_m(rwm), .i_rd_addr_w(rd_w), .i_regwrite_w(rww),
      .i_pcsrc_e(pcsrc), .i_dmem_busy(busy), .o_fwd_sel(fwd1),
      .o_stall_f(sf1), .o_stall_d(sd1), .o_stall_e(se1), .o_stall_m(sm1),
      .o_flush_d(fd1), .o_flush_e(fe1), .o_flush_w(fw1),
      .o_stall_cnt(sc1), .o_flush_cnt(fc1));

   hazard_ctrl #(.ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(3)) u3 (
      .i_clk(clk), .i_rst(rst), .i_rs_addr_d(rs_d), .i_rs_addr_e(rs_e),
      .i_rd_addr_e(rd_e), .i_regwrite_e(rwe), .i_memread_e(mre),
      .i_rd_addr_m(rd_m), .i_regwrite_m(rwm), .i_rd_addr_w(rd_w), .i_regwrite_w(rww),
      .i_pcsrc_e(pcsrc), .i_dmem_busy(busy), .o_fwd_sel(fwd3),
      .o_stall_f(sf3), .o_stall_d(sd3), .o_stall_e(se3), .o_stall_m(sm3),
      .o_flush_d(fd3), .o_flush_e(fe3), .o_flush_w(fw3),
      .o_stall_cnt(sc3), .o_flush_cnt(fc3));

   assign act1 = {fwd1, sf1, sd1, se1, sm1, fd1, fe1, fw1};
   assign act3 = {fwd3, sf3, sd3, se3, sm3, fd3, fe3, fw3};

   function automatic longint ecnt(input longint v);
      return CNT_EN ? v : 64'd0;
   endfunction

   task automatic idle_inputs();
      rwe = 0; mre = 0; rwm = 0; rww = 0; pcsrc = 0; busy = 0;
      rs_d = '0; rs_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
   endtask

   // Model: a load-use hazard owes LOAD_LAT bubbles; a busy memory freezes everything; a branch cancels owed bubbles.
   task automatic settle();
      logic [3:0] f;
      logic [4:0] a;
      logic       lu, sf, sd, se, sm, fd, fe, fw;
      @(negedge clk);
      f  = '0;
      lu = 1'b0;
      for (int k = 0; k < 2; k++) begin
         a = rs_e[k*5 +: 5];
         if (rwm && rd_m != 0 && rd_m == a) f[2*k +: 2] = 2'b10;
         else if (rww && rd_w != 0 && rd_w == a) f[2*k +: 2] = 2'b01;
         if (rd_e == rs_d[k*5 +: 5]) lu = 1'b1;
      end
      lu = lu & mre & rwe & (rd_e != 0);
      for (int i = 0; i < 2; i++) begin
         {sf, sd, se, sm, fd, fe, fw} = '0;
         nleft[i] = left[i];
         if (busy) begin
            {sf, sd, se, sm, fw} = '1;
         end else if (left[i] > 0) begin
            if (pcsrc) begin fd = 1; fe = 1; nleft[i] = 0; end
            else begin sf = 1; sd = 1; fe = 1; nleft[i] = left[i] - 1; end
         end else if (pcsrc) begin
            fd = 1; fe = 1;
         end else if (lu) begin
            sf = 1; sd = 1; fe = 1; nleft[i] = lat_tab[i] - 1;
         end
         exp_o[i] = rst ? 11'd0 : {f, sf, sd, se, sm, fd, fe, fw};
      end
   endtask

   task automatic advance();
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            left[i] = 0; msc[i] = 0; mfc[i] = 0;
         end else begin
            left[i] = nleft[i];
            if (exp_o[i][5] && msc[i] < cmax[i]) msc[i]++;
            if (exp_o[i][2] && mfc[i] < cmax[i]) mfc[i]++;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      settle();
      advance();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1; busy = 1'b1; pcsrc = 1'b1; rwm = 1'b1; rd_m = 5'd3; rs_e = 10'd3;
      for (int c = 0; c < 2; c++) begin
         settle();
         checks++;
         if (act1 !== 11'd0 || act3 !== 11'd0) begin
            errors++; $display("FAIL reset_outputs cyc %0d: got %b/%b expected all zero", c, act1, act3);
         end
         if (c == 1) begin
            checks++;
            if (sc1 !== 32'd0 || fc1 !== 32'd0 || sc3 !== 3'd0 || fc3 !== 3'd0) begin
               errors++; $display("FAIL reset_counters: got %0d %0d %0d %0d expected 0", sc1, fc1, sc3, fc3);
            end
         end
         advance();
      end
      rst = 1'b0;
      idle_inputs();
   endtask

   task automatic test_forwarding();
      logic [1:0] req[3] = '{2'b10, 2'b01, 2'b00};
      do_reset();
      for (int c = 0; c < 3; c++) begin
         idle_inputs();
         rww = 1'b1;
         rwm = (c != 1);
         rd_m = (c == 2) ? 5'd0 : 5'd5;
         rd_w = (c == 2) ? 5'd0 : 5'd5;
         rs_e = (c == 2) ? 10'd0 : {5'd9, 5'd5};
         settle();
         checks++;
         if (fwd1[1:0] !== req[c] || fwd3[1:0] !== req[c]) begin
            errors++; $display("FAIL fwd_case%0d: got %b/%b expected %b", c, fwd1[1:0], fwd3[1:0], req[c]);
         end
         checks++;
         if (act1 !== exp_o[0]) begin
            errors++; $display("FAIL fwd_vec%0d: got %b expected %b", c, act1, exp_o[0]);
         end
         advance();
      end
   endtask

   task automatic test_load_use_lat1();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         idle_inputs();
         rs_d = {5'd7, 5'd2};
         if (c == 0) begin mre = 1; rwe = 1; rd_e = 5'd7; end
         settle();
         checks++;
         if (act1 !== ((c == 0) ? V_LU : 11'd0)) begin
            errors++; $display("FAIL lu_lat1 cyc %0d: got %b expected %b", c, act1, (c == 0) ? V_LU : 11'd0);
         end
         if (c == 2) begin
            checks++;
            if (longint'(sc1) !== ecnt(1)) begin
               errors++; $display("FAIL lu_lat1_stallcnt: got %0d expected %0d", sc1, ecnt(1));
            end
         end
         advance();
      end
   endtask

   task automatic test_load_lat3_branch();
      for (int br = 0; br < 2; br++) begin
         do_reset();
         for (int c = 0; c < 5; c++) begin
            idle_inputs();
            rs_d = {5'd7, 5'd1};
            if (c == 0) begin mre = 1; rwe = 1; rd_e = 5'd7; end
            if (br == 1 && c == 1) pcsrc = 1'b1;
            settle();
            checks++;
            if (br == 0 && act3 !== ((c < 3) ? V_LU : 11'd0)) begin
               errors++; $display("FAIL lat3_stall cyc %0d: got %b expected %b", c, act3, (c < 3) ? V_LU : 11'd0);
            end
            if (br == 1 && act3 !== ((c == 0) ? V_LU : (c == 1) ? V_BR : 11'd0)) begin
               errors++; $display("FAIL lat3_branch cyc %0d: got %b expected %b", c, act3,
                                  (c == 0) ? V_LU : (c == 1) ? V_BR : 11'd0);
            end
            checks++;
            if (longint'(sc3) !== ecnt(msc[1]) || longint'(fc3) !== ecnt(mfc[1])) begin
               errors++; $display("FAIL lat3_counters cyc %0d: got %0d/%0d expected %0d/%0d", c, sc3, fc3,
                                  ecnt(msc[1]), ecnt(mfc[1]));
            end
            advance();
         end
      end
   endtask

   task automatic test_branch_loaduse();
      do_reset();
      for (int c = 0; c < 2; c++) begin
         idle_inputs();
         if (c == 0) begin pcsrc = 1; mre = 1; rwe = 1; rd_e = 5'd4; rs_d = {5'd4, 5'd0}; end
         settle();
         checks++;
         if (act1 !== ((c == 0) ? V_BR : 11'd0) || act3 !== ((c == 0) ? V_BR : 11'd0)) begin
            errors++; $display("FAIL br_lu cyc %0d: got %b/%b expected %b", c, act1, act3, (c == 0) ? V_BR : 11'd0);
         end
         if (c == 1) begin
            checks++;
            if (longint'(fc1) !== ecnt(1) || longint'(fc3) !== ecnt(1) || sc1 !== 32'd0 || sc3 !== 3'd0) begin
               errors++; $display("FAIL br_lu_counters: got fc %0d/%0d sc %0d/%0d expected fc %0d sc 0",
                                  fc1, fc3, sc1, sc3, ecnt(1));
            end
         end
         advance();
      end
   endtask

   task automatic test_mem_wait_in_load();
      logic [10:0] req;
      do_reset();
      for (int c = 0; c < 8; c++) begin
         idle_inputs();
         rs_d = {5'd0, 5'd6};
         if (c == 0) begin mre = 1; rwe = 1; rd_e = 5'd6; end
         busy = (c >= 1 && c <= 4);
         req  = (c >= 1 && c <= 4) ? V_MW : (c == 0 || c == 5 || c == 6) ? V_LU : 11'd0;
         settle();
         checks++;
         if (act3 !== req) begin
            errors++; $display("FAIL memwait_lat3 cyc %0d: got %b expected %b", c, act3, req);
         end
         checks++;
         if (act1 !== exp_o[0]) begin
            errors++; $display("FAIL memwait_lat1 cyc %0d: got %b expected %b", c, act1, exp_o[0]);
         end
         advance();
      end
   endtask

   task automatic test_reset_mid_memwait();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         idle_inputs();
         busy = (c < 2);
         rst  = (c == 1);
         settle();
         checks++;
         if (act1 !== ((c == 0) ? V_MW : 11'd0) || act3 !== ((c == 0) ? V_MW : 11'd0)) begin
            errors++; $display("FAIL rst_memwait cyc %0d: got %b/%b expected %b", c, act1, act3,
                               (c == 0) ? V_MW : 11'd0);
         end
         if (c == 2) begin
            checks++;
            if (sc1 !== 32'd0 || fc1 !== 32'd0 || sc3 !== 3'd0 || fc3 !== 3'd0) begin
               errors++; $display("FAIL rst_memwait_counters: got %0d %0d %0d %0d expected 0", sc1, fc1, sc3, fc3);
            end
         end
         advance();
      end
      rst = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rst     = ($urandom_range(0, 99) < 2);
         busy    = ($urandom_range(0, 99) < 20);
         pcsrc   = ($urandom_range(0, 99) < 12);
         mre     = ($urandom_range(0, 99) < 45);
         rwe     = ($urandom_range(0, 99) < 80);
         rwm     = $urandom_range(0, 1);
         rww     = $urandom_range(0, 1);
         rd_e    = 5'($urandom_range(0, 3));
         rd_m    = 5'($urandom_range(0, 3));
         rd_w    = 5'($urandom_range(0, 3));
         rs_d    = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         rs_e    = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         settle();
         checks++;
         if (act1 !== exp_o[0]) begin
            errors++; $display("FAIL rand_u1 cyc %0d: got %b expected %b", c, act1, exp_o[0]);
         end
         checks++;
         if (act3 !== exp_o[1]) begin
            errors++; $display("FAIL rand_u3 cyc %0d: got %b expected %b", c, act3, exp_o[1]);
         end
         checks++;
         if (longint'(sc1) !== ecnt(msc[0]) || longint'(fc1) !== ecnt(mfc[0]) ||
             longint'(sc3) !== ecnt(msc[1]) || longint'(fc3) !== ecnt(mfc[1])) begin
            errors++; $display("FAIL rand_counters cyc %0d: got %0d %0d %0d %0d expected %0d %0d %0d %0d", c,
                               sc1, fc1, sc3, fc3, ecnt(msc[0]), ecnt(mfc[0]), ecnt(msc[1]), ecnt(mfc[1]));
         end
         advance();
      end
      rst = 1'b0;
   endtask

   initial begin
      left = '{0, 0}; nleft = '{0, 0}; msc = '{0, 0}; mfc = '{0, 0};
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_forwarding();
      test_load_use_lat1();
      test_load_lat3_branch();
      test_branch_loaduse();
      test_mem_wait_in_load();
      test_reset_mid_memwait();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised hazard controller for the 5-stage core (F/D/E/M/W).
- Merges operand forwarding, load-use stalling, branch flushing and data-memory wait handling into one block.
- Replaces the fixed 2-operand, forward-only unit.
- Drives stall/flush enables of the pipeline registers and forward selects of the E-stage operand muxes.
- Optional saturating performance counters for stall and flush cycles.

Parameters:
ADDR_W, 5, register-address width; address 0 is the hard-wired zero register.
NUM_SRC, 2, source operands per instruction checked in D and E (1..4).
LOAD_LAT, 1, load-use bubbles inserted per hazard (1..15).
CNT_W, 32, performance-counter width.

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  synchronous reset, active-high.
i_rs_addr_d  in  NUM_SRC*ADDR_W  source addresses of instruction in D; operand k at [k*ADDR_W +: ADDR_W].
i_rs_addr_e  in  NUM_SRC*ADDR_W  source addresses of instruction in E, same packing.
i_rd_addr_e  in  ADDR_W  destination of instruction in E.
i_regwrite_e  in  1  instruction in E writes the register file.
i_memread_e  in  1  instruction in E is a load.
i_rd_addr_m  in  ADDR_W  destination in M.
i_regwrite_m  in  1  M writes the register file.
i_rd_addr_w  in  ADDR_W  destination in W.
i_regwrite_w  in  1  W writes the register file.
i_pcsrc_e  in  1  taken branch/jump resolved in E.
i_dmem_busy  in  1  data memory has not completed the access in M.
o_fwd_sel  out  NUM_SRC*2  per operand: 00 register file, 01 from W, 10 from M.
o_stall_f  out  1  hold PC.
o_stall_d  out  1  hold F/D register.
o_stall_e  out  1  hold D/E register.
o_stall_m  out  1  hold E/M register.
o_flush_d  out  1  clear F/D register to a bubble.
o_flush_e  out  1  clear D/E register to a bubble.
o_flush_w  out  1  clear M/W register to a bubble.
o_stall_cnt  out  CNT_W  cycles with o_stall_d=1.
o_flush_cnt  out  CNT_W  branch-flush cycles.

Behaviour:
Clock and reset:
- Single clock i_clk.
- Reset i_rst is synchronous, active-high.
- State and counters are registered. All outputs are combinational from registered state plus current inputs, so a response takes effect in the same cycle.

Reset:
- While i_rst=1 every stall, flush and o_fwd_sel output is 0.
- On the first edge with i_rst=1: state=RUN, bubble counter=0, both perf counters=0.
- A reset mid-LOAD_WAIT or mid-MEM_WAIT abandons the wait with no residual stall.

Forwarding (combinational, all states), per operand k:
- 10 if i_regwrite_m and rd_m!=0 and rd_m==rs_e[k];
- else 01 if i_regwrite_w and rd_w!=0 and rd_w==rs_e[k];
- else 00.
- M has priority over W. Address 0 never forwards.

Load-use hazard:
- Condition: i_memread_e and i_regwrite_e and rd_e!=0 and rd_e equals any rs_d[k].

FSM states:
- RUN:
  - i_dmem_busy=1 -> MEM_WAIT (outputs as MEM_WAIT this cycle).
  - Else if i_pcsrc_e -> o_flush_d=o_flush_e=1; stay RUN. Branch wins over a simultaneous load-use; the dependent instruction is flushed.
  - Else if load-use -> o_stall_f=o_stall_d=1, o_flush_e=1. If LOAD_LAT>1: go to LOAD_WAIT with counter=LOAD_LAT-1; else stay RUN.
- LOAD_WAIT:
  - Drives o_stall_f=o_stall_d=o_flush_e=1 each cycle; counter decrements.
  - Counter reaching 1 and decrementing returns to RUN next edge.
  - i_pcsrc_e=1 -> flush D/E, return to RUN, counter cleared.
  - i_dmem_busy=1 -> MEM_WAIT behaviour; counter frozen, LOAD_WAIT resumed afterwards via a saved return state.
- MEM_WAIT:
  - Drives o_stall_f/d/e/m=1 and o_flush_w=1. The M instruction retires exactly once; W receives bubbles.
  - No D/E flushes while busy; a pending i_pcsrc_e or load-use is acted on in the first cycle busy=0.
  - Exit to the saved state on the first edge with i_dmem_busy=0.

Counters:
- o_stall_cnt increments on each cycle with o_stall_d=1.
- o_flush_cnt increments on each cycle with a branch flush.
- Both saturate at all-ones.

Optional Feature:
HAZARD_PERF_CNT_EN:
- Defined: counters behave as above.
- Undefined: counter registers are removed, o_stall_cnt and o_flush_cnt are tied to 0, ports retained.

Test Plan:
- Forward priority: rd_m=5 and rd_w=5, both regwrite=1, rs_e[0]=5 -> o_fwd_sel[1:0]=10. Repeat with regwrite_m=0 -> 01. rs_e=0 with rd_m=0 -> 00.
- Load-use, LOAD_LAT=1: load rd_e=7, rs_d[1]=7 -> exactly 1 cycle o_stall_f/d=1 and o_flush_e=1; then RUN, o_stall_cnt=1.
- Load-use, LOAD_LAT=3 -> 3 consecutive stall cycles. With i_pcsrc_e pulsed on the 2nd cycle: flush D/E that cycle, stall ends, state RUN.
- Branch plus load-use in the same cycle -> o_flush_d=o_flush_e=1, no stall, o_flush_cnt=1.
- i_dmem_busy high 4 cycles during LOAD_WAIT (LOAD_LAT=3, after 1st bubble) -> 4 cycles all stalls plus o_flush_w; then 2 remaining bubbles.
- i_rst asserted mid-MEM_WAIT -> next cycle all outputs 0, counters 0. With HAZARD_PERF_CNT_EN undefined, counters read 0 throughout.
